// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg -- shared definitions for the camera configuration sequencer.
//   * I2C/SCCB master command codes
//   * special table entry codes (terminator, delay)
//   * per-entry phase numbers and the sequencer state enum
package cam_cfg_pkg;

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  // Bus phases of one register write: START, WR dev, WR reg, WR val, STOP
  localparam logic [2:0] PH_START = 3'd0;
  localparam logic [2:0] PH_DEV   = 3'd1;
  localparam logic [2:0] PH_REG   = 3'd2;
  localparam logic [2:0] PH_VAL   = 3'd3;
  localparam logic [2:0] PH_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT_LO, ST_WAIT_HI, ST_DELAY, ST_DONE, ST_ERR
  } state_e;

  function automatic logic [2:0] phase_cmd(input logic [2:0] ph);
    case (ph)
      PH_START: phase_cmd = CMD_START;
      PH_STOP:  phase_cmd = CMD_STOP;
      default:  phase_cmd = CMD_WR;
    endcase
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// cam_cfg_rom -- synchronous configuration table ROM, one-cycle read latency.
// Ports:
//   clk   in   clock
//   addr  in   table index
//   data  out  16-bit entry {reg, val}, registered
// Entry i of INIT lives at bits [16*i +: 16].
module cam_cfg_rom #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH),
  parameter logic [16*DEPTH-1:0] INIT = '1
) (
  input  logic          clk,
  input  logic [IW-1:0] addr,
  output logic [15:0]   data
);

  logic [15:0] data_d, data_q;

  always_comb data_d = INIT[{addr, 4'b0000} +: 16];

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer -- walks a register table and writes each entry to an
// SCCB camera through a byte-level I2C master.
// Each entry: START, WR DEV_ADDR, WR reg, WR val, STOP.
// 16'hFFFF ends the table, 16'hFFF0 waits DELAY_CYCLES with no bus traffic.
// Build option: CAM_CFG_RETRY_EN -- when defined, a NACKed entry is retried
// up to 3 times (after its STOP) before the run aborts; otherwise the first
// NACK aborts the run after STOP.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             pulse, begins a run (only honoured when idle)
//   i2c_ready         master can accept a command
//   i2c_done_tick     master finished a byte
//   i2c_ack           slave ack bit (0 = ACK)
//   i2c_cmd, i2c_din  registered command / byte to the master
//   i2c_wr            one-cycle command strobe
//   busy              run in progress
//   cfg_done, err     level status of the last run
//   err_idx           table index of the failed entry
// ROM_INIT holds the table (entry i at bits [16*i +: 16]); ROM_DEPTH >= 2,
// DELAY_CYCLES >= 1.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         ROM_DEPTH    = 64,
  parameter int         DELAY_CYCLES = 1_000_000,
  parameter logic [16*ROM_DEPTH-1:0] ROM_INIT = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         i2c_ready,
  input  logic                         i2c_done_tick,
  input  logic                         i2c_ack,
  output logic [2:0]                   i2c_cmd,
  output logic [7:0]                   i2c_din,
  output logic                         i2c_wr,
  output logic                         busy,
  output logic                         cfg_done,
  output logic                         err,
  output logic [$clog2(ROM_DEPTH)-1:0] err_idx
);

  localparam int IW = $clog2(ROM_DEPTH);
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(ROM_DEPTH - 1);
  localparam logic [CW-1:0] DELAY_END = CW'(DELAY_CYCLES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [2:0]    phase_q, phase_d;
  logic          ack_q, ack_d;     // NACK seen on the current byte
  logic          nack_q, nack_d;   // STOP in flight is the abort STOP of a NACK
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [7:0]    din_q, din_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [IW-1:0] eidx_q, eidx_d;
`ifdef CAM_CFG_RETRY_EN
  logic [1:0]    retry_q, retry_d;
`endif

  logic [15:0] entry;
  logic        nack_now;

  // Addressed with the next index so the entry is valid during FETCH.
  cam_cfg_rom #(.DEPTH(ROM_DEPTH), .IW(IW), .INIT(ROM_INIT)) u_rom (
    .clk  (clk),
    .addr (index_d),
    .data (entry)
  );

  // A done tick and ready may arrive together; include the live ack.
  assign nack_now = ack_q | (i2c_done_tick & (cmd_q == CMD_WR) & i2c_ack);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    phase_d = phase_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
`ifdef CAM_CFG_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        busy_d  = 1'b1;
        index_d = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        phase_d = PH_START;
        nack_d  = 1'b0;
`ifdef CAM_CFG_RETRY_EN
        retry_d = 2'd0;
`endif
        if (entry == ENTRY_END)        state_d = ST_DONE;
        else if (entry == ENTRY_DELAY) begin
          cnt_d   = '0;
          state_d = ST_DELAY;
        end else                       state_d = ST_ISSUE;
      end
      ST_ISSUE: if (i2c_ready) begin
        wr_d  = 1'b1;
        ack_d = 1'b0;
        cmd_d = phase_cmd(phase_q);
        case (phase_q)
          PH_DEV:  din_d = DEV_ADDR;
          PH_REG:  din_d = entry[15:8];
          PH_VAL:  din_d = entry[7:0];
          default: din_d = din_q;
        endcase
        state_d = ST_WAIT_LO;
      end
      // Ready is still high right after the strobe; wait for the master to
      // take it so a stale ready never triggers a second strobe.
      ST_WAIT_LO: if (!i2c_ready) state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (i2c_done_tick && cmd_q == CMD_WR) ack_d = i2c_ack;
        if (i2c_ready) begin
          if (phase_q == PH_STOP) begin
            if (nack_q) begin
`ifdef CAM_CFG_RETRY_EN
              if (retry_q != 2'd3) begin
                retry_d = retry_q + 2'd1;
                phase_d = PH_START;
                nack_d  = 1'b0;
                state_d = ST_ISSUE;
              end else state_d = ST_ERR;
`else
              state_d = ST_ERR;
`endif
            end else if (index_q == LAST_IDX) state_d = ST_DONE;
            else begin
              index_d = index_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else if (nack_now) begin
            // Close the bus before aborting or retrying.
            phase_d = PH_STOP;
            nack_d  = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            phase_d = phase_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == DELAY_END) begin
          if (index_q == LAST_IDX) state_d = ST_DONE;
          else begin
            index_d = index_q + 1'b1;
            state_d = ST_FETCH;
          end
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d   = 1'b1;
        eidx_d  = index_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      phase_q <= PH_START;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= CMD_STOP;
      din_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
`ifdef CAM_CFG_RETRY_EN
      retry_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      phase_q <= phase_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
`ifdef CAM_CFG_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign i2c_cmd  = cmd_q;
  assign i2c_din  = din_q;
  assign i2c_wr   = wr_q;
  assign busy     = busy_q;
  assign cfg_done = done_q;
  assign err      = err_q;
  assign err_idx  = eidx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: three instances (ROM_DEPTH=4, DELAY_CYCLES=10)
// each paired with a behavioural I2C master.
//   gm[0]: {12 80, FF F0, 11 01, FF FF}  main / slow / NACK / reset scenarios
//   gm[1]: {FF FF, ...}                  empty table
//   gm[2]: {33 44, 55 66, 77 88, 99 AA}  no terminator, last index ends run
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] start_v = '0;
  int cyc = 0;

  int n_chk = 0;
  int n_err = 0;

  // master model knobs, written only by the main sequence
  logic [7:0] nack_byte [3] = '{8'h00, 8'h00, 8'h00};
  int         nack_req  [3] = '{0, 0, 0};
  bit         slow      [3] = '{1'b0, 1'b0, 1'b0};

  // expected bus traffic for gm[0] with no errors
  logic [2:0] exp_cmd [10] = '{CMD_START, CMD_WR, CMD_WR, CMD_WR, CMD_STOP,
                               CMD_START, CMD_WR, CMD_WR, CMD_WR, CMD_STOP};
  logic [7:0] exp_din [10] = '{8'h00, 8'h42, 8'h12, 8'h80, 8'h00,
                               8'h00, 8'h42, 8'h11, 8'h01, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gm
    localparam logic [63:0] TBL = (g == 0) ? 64'hFFFF_1101_FFF0_1280 :
                                  (g == 1) ? 64'hFFFF_FFFF_FFFF_FFFF :
                                             64'h99AA_7788_5566_3344;
    logic       ready, tick, ack, wr, busy, done, err;
    logic [2:0] cmd;
    logic [7:0] din;
    logic [1:0] eidx;
    logic [2:0] lcmd [64];
    logic [7:0] ldin [64];
    int         lcyc [64];
    int         log_n = 0;
    int         dup = 0;
    int         nack_used = 0;
    logic [2:0] cur_cmd;
    logic [7:0] cur_din;
    int         st;

    cam_cfg_sequencer #(
      .DEV_ADDR(8'h42), .ROM_DEPTH(4), .DELAY_CYCLES(10), .ROM_INIT(TBL)
    ) dut (
      .clk(clk), .reset(reset), .start(start_v[g]),
      .i2c_ready(ready), .i2c_done_tick(tick), .i2c_ack(ack),
      .i2c_cmd(cmd), .i2c_din(din), .i2c_wr(wr),
      .busy(busy), .cfg_done(done), .err(err), .err_idx(eidx)
    );

    // Master: after a strobe, ready drops one cycle later (two if slow),
    // a done tick follows, then ready returns.
    initial begin
      ready = 1'b1; tick = 1'b0; ack = 1'b0; st = 0;
      cur_cmd = '0; cur_din = '0;
      forever begin
        @(posedge clk); #1;
        tick = 1'b0; ack = 1'b0;
        if (reset) begin
          ready = 1'b1; st = 0;
        end else begin
          if (wr && st != 0) dup++;
          case (st)
            0: if (wr) begin
              cur_cmd = cmd; cur_din = din;
              if (log_n < 64) begin
                lcmd[log_n] = cmd; ldin[log_n] = din; lcyc[log_n] = cyc;
              end
              log_n++;
              st = slow[g] ? 1 : 2;
            end
            1: st = 2;
            2: begin ready = 1'b0; st = 3; end
            3: st = 4;
            4: begin
              tick = 1'b1;
              if (cur_cmd == CMD_WR && cur_din == nack_byte[g] && nack_used < nack_req[g]) begin
                ack = 1'b1; nack_used++;
              end
              st = 5;
            end
            default: begin ready = 1'b1; st = 0; end
          endcase
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int i);
    case (i)
      0:       return gm[0].busy;
      1:       return gm[1].busy;
      default: return gm[2].busy;
    endcase
  endfunction

  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int lim, input string tag);
    for (int k = 0; k < lim; k++) begin
      if (!busy_of(i)) return;
      tick_n(1);
    end
    chk({tag, "_timeout"}, busy_of(i), 0);
  endtask

  task automatic wait_log0(input int n, input int lim);
    for (int k = 0; k < lim; k++) begin
      if (gm[0].log_n >= n) return;
      tick_n(1);
    end
    chk("log_timeout", gm[0].log_n, n);
  endtask

  initial begin
    int base, n0, starts;
    tick_n(3);
    chk("rst_wr",   gm[0].wr,   0);
    chk("rst_cmd",  gm[0].cmd,  3'b011);
    chk("rst_din",  gm[0].din,  0);
    chk("rst_busy", gm[0].busy, 0);
    chk("rst_done", gm[0].done, 0);
    chk("rst_err",  gm[0].err,  0);
    chk("rst_eidx", gm[0].eidx, 0);
    reset = 1'b0;
    tick_n(2);

    // normal run with a delay entry
    base = gm[0].log_n;
    pulse(0);
    chk("run_busy", gm[0].busy, 1);
    wait_idle(0, 400, "run");
    chk("run_done", gm[0].done, 1);
    chk("run_err",  gm[0].err,  0);
    chk("run_nstb", gm[0].log_n - base, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("run_cmd%0d", k), gm[0].lcmd[base+k], exp_cmd[k]);
      if (exp_cmd[k] == CMD_WR)
        chk($sformatf("run_din%0d", k), gm[0].ldin[base+k], exp_din[k]);
    end
    // STOP->START: 5 cycles bus wait, FETCH of delay entry, 10 delay
    // cycles, FETCH, ISSUE, strobe = 18
    chk("run_gap", gm[0].lcyc[base+5] - gm[0].lcyc[base+4], 18);
    chk("run_dup", gm[0].dup, 0);

    // empty table: done two cycles after start, no traffic
    start_v[1] = 1'b1;
    tick_n(1);
    start_v[1] = 1'b0;
    tick_n(1);
    chk("empty_done_early", gm[1].done, 0);
    tick_n(1);
    chk("empty_done", gm[1].done, 1);
    chk("empty_busy", gm[1].busy, 0);
    chk("empty_nstb", gm[1].log_n, 0);

    // no terminator: all four entries run, then done
    pulse(2);
    wait_idle(2, 600, "last");
    chk("last_nstb", gm[2].log_n, 20);
    chk("last_din",  gm[2].ldin[18], 8'hAA);
    chk("last_cmd",  gm[2].lcmd[19], CMD_STOP);
    chk("last_done", gm[2].done, 1);
    chk("last_err",  gm[2].err,  0);

    // slow master: ready lingers one extra cycle after each strobe
    slow[0] = 1'b1;
    base = gm[0].log_n;
    pulse(0);
    wait_idle(0, 400, "slow");
    chk("slow_nstb", gm[0].log_n - base, 10);
    chk("slow_dup",  gm[0].dup, 0);
    chk("slow_done", gm[0].done, 1);
    slow[0] = 1'b0;

`ifdef CAM_CFG_RETRY_EN
    // one NACK on entry 0's reg byte: one retry, run completes
    nack_byte[0] = 8'h12;
    nack_req[0]  = nack_req[0] + 1;
    base = gm[0].log_n;
    pulse(0);
    wait_idle(0, 600, "retry");
    starts = 0;
    for (int k = base; k < gm[0].log_n; k++) if (gm[0].lcmd[k] == CMD_START) starts++;
    chk("retry_nstb",   gm[0].log_n - base, 14);
    chk("retry_starts", starts, 3);
    chk("retry_done",   gm[0].done, 1);
    chk("retry_err",    gm[0].err,  0);
    // persistent NACK on entry 2: 4 attempts, then abort
    nack_byte[0] = 8'h11;
    nack_req[0]  = nack_req[0] + 4;
    base = gm[0].log_n;
    pulse(0);
    wait_idle(0, 800, "exh");
    chk("exh_nstb", gm[0].log_n - base, 21);
    chk("exh_stop", gm[0].lcmd[gm[0].log_n-1], CMD_STOP);
    chk("exh_err",  gm[0].err,  1);
    chk("exh_eidx", gm[0].eidx, 2);
    chk("exh_done", gm[0].done, 0);
`else
    // NACK on entry 2's reg byte: STOP, then abort
    nack_byte[0] = 8'h11;
    nack_req[0]  = nack_req[0] + 1;
    base = gm[0].log_n;
    pulse(0);
    wait_idle(0, 400, "nack");
    chk("nack_nstb", gm[0].log_n - base, 9);
    chk("nack_stop", gm[0].lcmd[gm[0].log_n-1], CMD_STOP);
    chk("nack_err",  gm[0].err,  1);
    chk("nack_eidx", gm[0].eidx, 2);
    chk("nack_busy", gm[0].busy, 0);
    chk("nack_done", gm[0].done, 0);
`endif

    // start while busy is ignored; reset mid-byte aborts without STOP
    base = gm[0].log_n;
    pulse(0);
    wait_log0(base + 2, 100);
    pulse(0);
    wait_log0(base + 3, 100);
    chk("ign_cmd", gm[0].lcmd[base+2], CMD_WR);
    chk("ign_din", gm[0].ldin[base+2], 8'h12);
    reset = 1'b1;
    tick_n(2);
    chk("mid_wr",   gm[0].wr,   0);
    chk("mid_cmd",  gm[0].cmd,  3'b011);
    chk("mid_din",  gm[0].din,  0);
    chk("mid_busy", gm[0].busy, 0);
    chk("mid_done", gm[0].done, 0);
    chk("mid_err",  gm[0].err,  0);
    chk("mid_eidx", gm[0].eidx, 0);
    reset = 1'b0;
    n0 = gm[0].log_n;
    tick_n(30);
    chk("mid_quiet", gm[0].log_n, n0);
    chk("mid_idle",  gm[0].busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
